// File: rtl/hazard_pkg.sv
// Shared types and helpers for the scoreboard hazard controller.
package hazard_pkg;

   // Width of each per-register "cycles until readable" countdown.
   localparam int unsigned CNT_W = 2;

   typedef enum logic [1:0] {
      HZ_NONE    = 2'd0,
      HZ_RAW     = 2'd1,
      HZ_FLUSH   = 2'd2,
      HZ_MEMWAIT = 2'd3
   } hz_cause_e;

   // Bubbles a newly issued writer imposes on a dependent reader in Decode.
   // Without forwarding every writer waits for WB (one less if the register
   // file writes through); with forwarding only loads cost bubbles.
   function automatic logic [CNT_W-1:0] ready_lat(input logic             fwd_en,
                                                  input logic             rf_wt,
                                                  input logic [CNT_W-1:0] load_lat,
                                                  input logic             is_load);
      logic [CNT_W-1:0] lat;
      if (fwd_en) begin
         lat = is_load ? load_lat : '0;
      end else begin
         lat = rf_wt ? CNT_W'(2) : CNT_W'(3);
      end
      return lat;
   endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register countdown array: issue sets a count, all other non-zero
// counts decrement each unfrozen cycle, two combinational read ports.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_freeze,
   input  logic                  i_issue,
   input  logic [REG_ADDR_W-1:0] i_issue_addr,
   input  logic [CNT_W-1:0]      i_issue_lat,
   input  logic [REG_ADDR_W-1:0] i_rd_a_addr,
   input  logic [REG_ADDR_W-1:0] i_rd_b_addr,
   output logic [CNT_W-1:0]      o_rd_a_cnt,
   output logic [CNT_W-1:0]      o_rd_b_cnt
);

   localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;

   logic [CNT_W-1:0] cnt_q [NUM_REGS];
   logic [CNT_W-1:0] cnt_d [NUM_REGS];

   // Next-state: newest writer overwrites, everything else counts down unless frozen.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (!i_freeze) begin
            if (i_issue && (i_issue_addr == REG_ADDR_W'(i))) begin
               cnt_d[i] = i_issue_lat;
            end else if (cnt_q[i] != '0) begin
               cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
         end
      end
      // x0 is hardwired and can never be pending.
      cnt_d[0] = '0;
   end

   // Countdown state with asynchronous clear.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Source-operand read ports.
   always_comb begin
      o_rd_a_cnt = cnt_q[i_rd_a_addr];
      o_rd_b_cnt = cnt_q[i_rd_b_addr];
   end

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// Scoreboard-based RAW hazard controller for the RV32I pipeline.
// Optional macro HAZARD_PERF_EN adds saturating stall/flush event counters.
module hazard_scoreboard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned FWD_EN     = 0,
   parameter int unsigned RF_WT      = 1,
   parameter int unsigned LOAD_LAT   = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_id_valid,
   input  logic [REG_ADDR_W-1:0] i_id_rs1_addr,
   input  logic                  i_id_rs1_used,
   input  logic [REG_ADDR_W-1:0] i_id_rs2_addr,
   input  logic                  i_id_rs2_used,
   input  logic [REG_ADDR_W-1:0] i_id_rd_addr,
   input  logic                  i_id_rd_wren,
   input  logic                  i_id_is_load,
   input  logic                  i_ex_br_taken,
   input  logic                  i_mem_stall,
`ifdef HAZARD_PERF_EN
   output logic [31:0]           o_stall_cycles,
   output logic [31:0]           o_flush_events,
`endif
   output logic                  o_pc_en,
   output logic                  o_fd_en,
   output logic                  o_fd_flush,
   output logic                  o_de_flush,
   output logic                  o_stall,
   output logic [1:0]            o_cause
);

   logic [CNT_W-1:0] rs1_cnt;
   logic [CNT_W-1:0] rs2_cnt;
   logic [CNT_W-1:0] issue_lat;
   logic             raw;
   logic             issue;
   hz_cause_e        cause;

   hazard_scoreboard #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_scoreboard (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_freeze     (i_mem_stall),
      .i_issue      (issue),
      .i_issue_addr (i_id_rd_addr),
      .i_issue_lat  (issue_lat),
      .i_rd_a_addr  (i_id_rs1_addr),
      .i_rd_b_addr  (i_id_rs2_addr),
      .o_rd_a_cnt   (rs1_cnt),
      .o_rd_b_cnt   (rs2_cnt)
   );

   // RAW detection and ready latency of the writer currently in Decode.
   always_comb begin
      raw = i_id_valid & ((i_id_rs1_used & (rs1_cnt != '0)) |
                          (i_id_rs2_used & (rs2_cnt != '0)));
      issue_lat = ready_lat((FWD_EN != 0), (RF_WT != 0), CNT_W'(LOAD_LAT), i_id_is_load);
   end

   // Prioritised pipeline control: memory wait, then redirect, then RAW.
   always_comb begin
      o_pc_en    = 1'b1;
      o_fd_en    = 1'b1;
      o_fd_flush = 1'b0;
      o_de_flush = 1'b0;
      o_stall    = 1'b0;
      cause      = HZ_NONE;
      if (i_mem_stall) begin
         o_pc_en = 1'b0;
         o_fd_en = 1'b0;
         cause   = HZ_MEMWAIT;
      end else if (i_ex_br_taken) begin
         // The dependent Decode instruction is killed, so no RAW stall is needed.
         o_fd_flush = 1'b1;
         o_de_flush = 1'b1;
         cause      = HZ_FLUSH;
      end else if (raw) begin
         o_pc_en    = 1'b0;
         o_fd_en    = 1'b0;
         o_de_flush = 1'b1;
         o_stall    = 1'b1;
         cause      = HZ_RAW;
      end
      o_cause = cause;
   end

   // Only an instruction that actually advances out of Decode is tracked.
   always_comb begin
      issue = i_id_valid & i_id_rd_wren & (i_id_rd_addr != '0) & (cause == HZ_NONE);
   end

`ifdef HAZARD_PERF_EN
   // Saturating performance counters.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_stall_cycles <= '0;
         o_flush_events <= '0;
      end else begin
         if (o_stall && (o_stall_cycles != 32'hFFFF_FFFF)) begin
            o_stall_cycles <= o_stall_cycles + 32'd1;
         end
         if (i_ex_br_taken && !i_mem_stall && (o_flush_events != 32'hFFFF_FFFF)) begin
            o_flush_events <= o_flush_events + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Scoreboard bench: three controller configurations share one stimulus bus;
// each expected vector names the instance it checks.
module tb_hazard_scoreboard_ctrl;

   // Expected {pc_en, fd_en, fd_flush, de_flush, stall, cause[1:0]}.
   localparam logic [6:0] E_NONE  = 7'b11_00_0_00;
   localparam logic [6:0] E_RAW   = 7'b00_01_1_01;
   localparam logic [6:0] E_FLUSH = 7'b11_11_0_10;
   localparam logic [6:0] E_MEM   = 7'b00_00_0_11;

   typedef struct {
      string      name;
      int         sel;
      logic [6:0] exp;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       id_valid = 1'b0;
   logic [4:0] rs1 = '0;
   logic       rs1_used = 1'b0;
   logic [4:0] rs2 = '0;
   logic       rs2_used = 1'b0;
   logic [4:0] rd = '0;
   logic       rd_wren = 1'b0;
   logic       is_load = 1'b0;
   logic       br_taken = 1'b0;
   logic       mem_stall = 1'b0;

   logic [2:0] pc_en, fd_en, fd_flush, de_flush, stall;
   logic [1:0] cause [3];
`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cycles [3];
   logic [31:0] flush_events [3];
`endif

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   // u0: no forwarding, write-through RF (L=2); u1: forwarding, LOAD_LAT=1;
   // u2: no forwarding, no write-through (L=3).
   for (genvar g = 0; g < 3; g++) begin : g_dut
      hazard_scoreboard_ctrl #(
         .REG_ADDR_W (5),
         .FWD_EN     ((g == 1) ? 1 : 0),
         .RF_WT      ((g == 2) ? 0 : 1),
         .LOAD_LAT   (1)
      ) u_dut (
         .i_clk          (clk),
         .i_rst_n        (rst_n),
         .i_id_valid     (id_valid),
         .i_id_rs1_addr  (rs1),
         .i_id_rs1_used  (rs1_used),
         .i_id_rs2_addr  (rs2),
         .i_id_rs2_used  (rs2_used),
         .i_id_rd_addr   (rd),
         .i_id_rd_wren   (rd_wren),
         .i_id_is_load   (is_load),
         .i_ex_br_taken  (br_taken),
         .i_mem_stall    (mem_stall),
`ifdef HAZARD_PERF_EN
         .o_stall_cycles (stall_cycles[g]),
         .o_flush_events (flush_events[g]),
`endif
         .o_pc_en        (pc_en[g]),
         .o_fd_en        (fd_en[g]),
         .o_fd_flush     (fd_flush[g]),
         .o_de_flush     (de_flush[g]),
         .o_stall        (stall[g]),
         .o_cause        (cause[g])
      );
   end

   // Monitor: outputs are valid every cycle, compared mid-cycle on the falling edge.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t       e;
         logic [6:0] got;
         e   = q.pop_front();
         got = {pc_en[e.sel], fd_en[e.sel], fd_flush[e.sel], de_flush[e.sel],
                stall[e.sel], cause[e.sel]};
         checks++;
         if (got !== e.exp) begin
            errors++;
            $display("FAIL %s (dut%0d): got %b required %b", e.name, e.sel, got, e.exp);
         end
      end
   end

   task automatic cyc(input string nm, input int sel, input logic v,
                      input logic [4:0] a1, input logic u1, input logic [4:0] a2,
                      input logic u2, input logic [4:0] d, input logic wr, input logic ld,
                      input logic br, input logic ms, input logic [6:0] exp);
      id_valid  = v;
      rs1       = a1;
      rs1_used  = u1;
      rs2       = a2;
      rs2_used  = u2;
      rd        = d;
      rd_wren   = wr;
      is_load   = ld;
      br_taken  = br;
      mem_stall = ms;
      q.push_back('{nm, sel, exp});
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_valid = 1'b0; rs1 = '0; rs1_used = 1'b0; rs2 = '0; rs2_used = 1'b0;
      rd = '0; rd_wren = 1'b0; is_load = 1'b0; br_taken = 1'b0; mem_stall = 1'b0;
   endtask

   // Asynchronous pulse well away from either clock edge.
   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

`ifdef HAZARD_PERF_EN
   task automatic check_perf(input string nm, input int sel, input logic [31:0] exp_st,
                             input logic [31:0] exp_fl);
      checks++;
      if (stall_cycles[sel] !== exp_st || flush_events[sel] !== exp_fl) begin
         errors++;
         $display("FAIL %s (dut%0d): got stall=%0d flush=%0d required stall=%0d flush=%0d",
                  nm, sel, stall_cycles[sel], flush_events[sel], exp_st, exp_fl);
      end
   endtask
`endif

   initial begin
      @(posedge clk);
      #1;
      do_reset();
      cyc("reset_idle_u0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE);
      cyc("reset_idle_u1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE);
      cyc("reset_idle_u2", 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE);

      // 1: add x5 then dependent adds, L=2 gives exactly two stalls.
      do_reset();
`ifdef HAZARD_PERF_EN
      check_perf("perf_after_reset", 0, 0, 0);
`endif
      cyc("s1_add_x5",      0, 1, 1, 1, 2, 1, 5, 1, 0, 0, 0, E_NONE);
      cyc("s1_use_x5_st1",  0, 1, 5, 1, 1, 1, 6, 1, 0, 0, 0, E_RAW);
      cyc("s1_use_x5_st2",  0, 1, 5, 1, 1, 1, 6, 1, 0, 0, 0, E_RAW);
      cyc("s1_use_x5_go",   0, 1, 5, 1, 1, 1, 6, 1, 0, 0, 0, E_NONE);
      cyc("s1_gap",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE);
      cyc("s1_rs2_x6_st",   0, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0, E_RAW);
      cyc("s1_rs2_x6_go",   0, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0, E_NONE);
`ifdef HAZARD_PERF_EN
      check_perf("perf_s1", 0, 3, 0);
`endif

      // 2: forwarding - load-use costs one bubble, ALU producer none.
      do_reset();
      cyc("s2_lw_x7",       1, 1, 2, 1, 0, 0, 7, 1, 1, 0, 0, E_NONE);
      cyc("s2_use_x7_st",   1, 1, 7, 1, 1, 1, 8, 1, 0, 0, 0, E_RAW);
      cyc("s2_use_x7_go",   1, 1, 7, 1, 1, 1, 8, 1, 0, 0, 0, E_NONE);
      cyc("s2_addi_x7",     1, 1, 1, 1, 0, 0, 7, 1, 0, 0, 0, E_NONE);
      cyc("s2_alu_use_x7",  1, 1, 7, 1, 8, 1, 10, 1, 0, 0, 0, E_NONE);

      // 3: x0 writer is never tracked; unused source does not stall.
      do_reset();
      cyc("s3_write_x0",    0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, E_NONE);
      cyc("s3_read_x0",     0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, E_NONE);
      cyc("s3_add_x5",      0, 1, 1, 1, 0, 0, 5, 1, 0, 0, 0, E_NONE);
      cyc("s3_unused_rs1",  0, 1, 5, 0, 3, 1, 0, 0, 0, 0, 0, E_NONE);
      cyc("s3_invalid_rd",  0, 0, 5, 1, 5, 1, 0, 0, 0, 0, 0, E_NONE);

      // 4: taken branch overrides RAW, kills the D writer, counts keep running.
      do_reset();
      cyc("s4_add_x5",      0, 1, 1, 1, 0, 0, 5, 1, 0, 0, 0, E_NONE);
      cyc("s4_raw",         0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, E_RAW);
      cyc("s4_flush",       0, 1, 5, 1, 0, 0, 6, 1, 0, 1, 0, E_FLUSH);
      cyc("s4_after_flush", 0, 1, 5, 1, 6, 1, 0, 0, 0, 0, 0, E_NONE);
`ifdef HAZARD_PERF_EN
      check_perf("perf_s4", 0, 1, 1);
`endif

      // 5: L=3, memory wait freezes cnt[5]=2; two stalls remain afterwards.
      do_reset();
      cyc("s5_add_x5",      2, 1, 1, 1, 0, 0, 5, 1, 0, 0, 0, E_NONE);
      cyc("s5_raw_pre",     2, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, E_RAW);
      cyc("s5_mem1",        2, 1, 5, 1, 0, 0, 6, 1, 0, 0, 1, E_MEM);
      cyc("s5_mem2_br",     2, 1, 5, 1, 0, 0, 6, 1, 0, 1, 1, E_MEM);
      cyc("s5_mem3",        2, 1, 5, 1, 0, 0, 6, 1, 0, 0, 1, E_MEM);
      cyc("s5_mem4",        2, 1, 0, 0, 0, 0, 6, 1, 0, 0, 1, E_MEM);
      cyc("s5_raw_post1",   2, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, E_RAW);
      cyc("s5_raw_post2",   2, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, E_RAW);
      cyc("s5_go",          2, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, E_NONE);
      cyc("s5_use_x6",      2, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, E_RAW);

      // 6: reset mid-countdown with cnt[9]=3 clears the pending writer.
      do_reset();
      cyc("s6_add_x9",      2, 1, 1, 1, 0, 0, 9, 1, 0, 0, 0, E_NONE);
      do_reset();
`ifdef HAZARD_PERF_EN
      check_perf("perf_s6_reset", 2, 0, 0);
`endif
      cyc("s6_read_x9",     2, 1, 9, 1, 9, 1, 0, 0, 0, 0, 0, E_NONE);
      idle_inputs();

      for (int i = 0; i < 20 && q.size() > 0; i++) begin
         @(posedge clk);
      end
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
